ps2_receiver: RTL and testbench

Receives PS/2 keyboard frames (device-to-host direction) and decodes scan-code set 2. It turns make and break codes into held-key levels for left, right and start. It sits beside move_bar and move_ball in top and is clocked by VGA_CLK (25 MHz). KEY[1:0] and SW[2] remain as alternative controls.

---
 rtl/ps2_receiver.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ps2_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_receiver.sv
// -----------------------------------------------------------------------------
// ps2_receiver
//
// Receives device-to-host PS/2 keyboard frames and decodes scan-code set 2
// into held-key levels for Left Arrow, Right Arrow and Space.
//
// Frame on the wire (sampled on falling ps2_clk edges):
//   start(0), d0..d7 (LSB first), odd parity, stop(1)
//
// Ports:
//   clock        in   system clock (VGA_CLK, 25 MHz)
//   reset        in   asynchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock from the connector (asynchronous)
//   ps2_dat      in   raw PS/2 data from the connector (asynchronous)
//   scan_code    out  last good byte received
//   code_valid   out  one-cycle pulse when scan_code is updated
//   frame_error  out  one-cycle pulse on start/parity/stop/timeout error
//   key_left     out  high while Left Arrow (E0 6B) is held
//   key_right    out  high while Right Arrow (E0 74) is held
//   key_start    out  high while Space (29) is held
// -----------------------------------------------------------------------------
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_error,
    output logic       key_left,
    output logic       key_right,
    output logic       key_start
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    // ---------------------------------------------------------------------
    // Input path registers
    // ---------------------------------------------------------------------
    logic [1:0]            clk_sync_q;
    logic [1:0]            dat_sync_q;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  level_q;
    logic                  level_d;
    logic                  fall_q;
    logic                  fall_d;
    logic                  dat_bit;

    // ---------------------------------------------------------------------
    // Frame FSM registers
    // ---------------------------------------------------------------------
    state_t           state_q,  state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shreg_q,  shreg_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] tmo_q,    tmo_d;
    logic             good_d;
    logic             err_d;

    // ---------------------------------------------------------------------
    // Decoder and output registers
    // ---------------------------------------------------------------------
    logic       brk_q,        brk_d;
    logic       ext_q,        ext_d;
    logic [7:0] scan_code_q,  scan_code_d;
    logic       code_valid_q;
    logic       frame_error_q;
    logic       key_left_q,   key_left_d;
    logic       key_right_q,  key_right_d;
    logic       key_start_q,  key_start_d;

    assign dat_bit = dat_sync_q[1];

    // Filtered clock level: it only flips once the whole sample window agrees
    // on the opposite value, so short glitches never reach the FSM.
    always_comb begin
        level_d = level_q;
        if (&filt_q) begin
            level_d = 1'b1;
        end else if (~|filt_q) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        fall_d = level_q & ~level_d;
    end

    // Synchronizers, glitch filter, filtered level and fall pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= {FILTER_LEN{1'b1}};
            level_q    <= 1'b1;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            filt_q     <= {filt_q[FILTER_LEN-2:0], clk_sync_q[1]};
            level_q    <= level_d;
            fall_q     <= fall_d;
        end
    end

    // Frame FSM next state, including the mid-frame timeout abort.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        parity_d = parity_q;
        tmo_d    = tmo_q;
        good_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = {CNT_W{1'b0}};
                if (fall_q) begin
                    if (!dat_bit) begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (fall_q) begin
                    shreg_d  = {dat_bit, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (fall_q) begin
                    parity_d = dat_bit;
                    state_d  = S_STOP;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (fall_q) begin
                    // Odd parity: data bits plus parity bit must XOR to 1.
                    if (dat_bit && ((^shreg_q) ^ parity_q)) begin
                        good_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Timeout runs in every non-idle state and restarts on each fall.
        if (state_q != S_IDLE) begin
            if (fall_q) begin
                tmo_d = {CNT_W{1'b0}};
            end else if (tmo_q == TMO_LAST) begin
                state_d  = S_IDLE;
                err_d    = 1'b1;
                tmo_d    = {CNT_W{1'b0}};
                bitcnt_d = 3'd0;
                shreg_d  = 8'h00;
            end else begin
                tmo_d = tmo_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            tmo_d = {CNT_W{1'b0}};
        end
    end

    // Scan-code decoder: prefixes set flags, any other byte consumes them.
    always_comb begin
        brk_d       = brk_q;
        ext_d       = ext_q;
        scan_code_d = scan_code_q;
        key_left_d  = key_left_q;
        key_right_d = key_right_q;
        key_start_d = key_start_q;

        if (good_d) begin
            scan_code_d = shreg_q;
            case (shreg_q)
                CODE_BREAK: begin
                    brk_d = 1'b1;
                end
                CODE_EXT: begin
                    ext_d = 1'b1;
                end
                default: begin
                    if (ext_q && (shreg_q == CODE_LEFT)) begin
                        key_left_d = ~brk_q;
                    end else if (ext_q && (shreg_q == CODE_RIGHT)) begin
                        key_right_d = ~brk_q;
                    end else if (!ext_q && (shreg_q == CODE_SPACE)) begin
                        key_start_d = ~brk_q;
                    end else begin
                        key_left_d = key_left_q;
                    end
                    brk_d = 1'b0;
                    ext_d = 1'b0;
                end
            endcase
        end else begin
            scan_code_d = scan_code_q;
        end
    end

    // FSM state, decoder flags and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bitcnt_q      <= 3'd0;
            shreg_q       <= 8'h00;
            parity_q      <= 1'b0;
            tmo_q         <= {CNT_W{1'b0}};
            brk_q         <= 1'b0;
            ext_q         <= 1'b0;
            scan_code_q   <= 8'h00;
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            key_left_q    <= 1'b0;
            key_right_q   <= 1'b0;
            key_start_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            parity_q      <= parity_d;
            tmo_q         <= tmo_d;
            brk_q         <= brk_d;
            ext_q         <= ext_d;
            scan_code_q   <= scan_code_d;
            code_valid_q  <= good_d;
            frame_error_q <= err_d;
            key_left_q    <= key_left_d;
            key_right_q   <= key_right_d;
            key_start_q   <= key_start_d;
        end
    end

    assign scan_code   = scan_code_q;
    assign code_valid  = code_valid_q;
    assign frame_error = frame_error_q;
    assign key_left    = key_left_q;
    assign key_right   = key_right_q;
    assign key_start   = key_start_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// -----------------------------------------------------------------------------
// tb_ps2_receiver
//
// Directed bench for ps2_receiver. Every good frame pushes its expected
// scan code and key levels onto a scoreboard; a monitor pops and compares
// on each code_valid pulse and also checks that key levels never move
// outside a code_valid cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_receiver;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_error;
    logic       key_left;
    logic       key_right;
    logic       key_start;

    typedef struct packed {
        logic [7:0] code;
        logic       l;
        logic       r;
        logic       s;
    } exp_t;

    exp_t exp_q[$];

    int checks     = 0;
    int errors     = 0;
    int cv_count   = 0;
    int err_pulses = 0;
    int err_cycles = 0;

    localparam int HALF_SLOW = 750;  // 60 us bit period at 25 MHz
    localparam int HALF_FAST = 50;

    // 25 MHz system clock.
    always #20 clock = ~clock;

    ps2_receiver dut (
        .clock       (clock),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .scan_code   (scan_code),
        .code_valid  (code_valid),
        .frame_error (frame_error),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_start   (key_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // start(0), 8 data bits LSB first, odd parity (optionally corrupted), stop(1)
    function automatic logic [10:0] mkframe(input logic [7:0] b, input logic bad);
        logic p;
        p = ~(^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            repeat (half) @(posedge clock);
            ps2_clk = 1'b0;
            repeat (half) @(posedge clock);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad, input int half);
        send_bits(mkframe(b, bad), 11, half);
        repeat (half) @(posedge clock);
    endtask

    task automatic push(input logic [7:0] code, input logic l, input logic r, input logic s);
        exp_q.push_back({code, l, r, s});
    endtask

    task automatic monitor();
        logic [2:0] prev_k;
        logic       prev_fe;
        exp_t       e;
        prev_k  = 3'b000;
        prev_fe = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_k  = 3'b000;
                prev_fe = 1'b0;
            end else begin
                if (code_valid) begin
                    cv_count++;
                    check("sb_nonempty", 16'(exp_q.size() != 0), 16'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_scan_code", 16'(scan_code), 16'(e.code));
                        check("sb_key_left",  16'(key_left),  16'(e.l));
                        check("sb_key_right", 16'(key_right), 16'(e.r));
                        check("sb_key_start", 16'(key_start), 16'(e.s));
                    end
                end
                if ({key_left, key_right, key_start} !== prev_k) begin
                    check("key_change_with_valid", 16'(code_valid), 16'd1);
                end
                if (frame_error) begin
                    err_cycles++;
                    if (!prev_fe) begin
                        err_pulses++;
                    end
                end
                prev_k  = {key_left, key_right, key_start};
                prev_fe = frame_error;
            end
        end
    endtask

    initial begin
        int  n;
        bit  got;
        logic [7:0] saved_code;
        int  saved_cv;
        int  saved_err;

        fork
            monitor();
        join_none

        // Reset state
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rst_outputs", 16'({scan_code, code_valid, frame_error,
                                  key_left, key_right, key_start}), 16'h0000);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        // Space make at a 60 us bit period
        push(8'h29, 1'b0, 1'b0, 1'b1);
        send_byte(8'h29, 1'b0, HALF_SLOW);
        check("t1_cv_count",  16'(cv_count), 16'd1);
        check("t1_err",       16'(err_pulses), 16'd0);
        check("t1_scan_code", 16'(scan_code), 16'h0029);
        check("t1_key_start", 16'(key_start), 16'd1);

        // Left Arrow make, then break
        push(8'hE0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, HALF_FAST);
        push(8'h6B, 1'b1, 1'b0, 1'b1);
        send_byte(8'h6B, 1'b0, HALF_FAST);
        check("t2_left_make", 16'(key_left), 16'd1);
        push(8'hE0, 1'b1, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, HALF_FAST);
        push(8'hF0, 1'b1, 1'b0, 1'b1);
        send_byte(8'hF0, 1'b0, HALF_FAST);
        push(8'h6B, 1'b0, 1'b0, 1'b1);
        send_byte(8'h6B, 1'b0, HALF_FAST);
        check("t2_left_break", 16'(key_left), 16'd0);
        check("t2_right",      16'(key_right), 16'd0);

        // E0 then 74 with bad parity; ext survives the error byte
        push(8'hE0, 1'b0, 1'b0, 1'b1);
        send_byte(8'hE0, 1'b0, HALF_FAST);
        send_byte(8'h74, 1'b1, HALF_FAST);
        check("t3_err",       16'(err_pulses), 16'd1);
        check("t3_scan_code", 16'(scan_code), 16'h00E0);
        check("t3_right_bad", 16'(key_right), 16'd0);
        push(8'h74, 1'b0, 1'b1, 1'b1);
        send_byte(8'h74, 1'b0, HALF_FAST);
        check("t3_right_good", 16'(key_right), 16'd1);

        // Timeout after start + 4 data bits
        send_bits(mkframe(8'h29, 1'b0), 5, HALF_FAST);
        n   = HALF_FAST;
        got = 1'b0;
        while (!got && n < 6000) begin
            @(negedge clock);
            n++;
            if (frame_error) begin
                got = 1'b1;
            end
        end
        check("t4_tmo_fired",  16'(got), 16'd1);
        check("t4_tmo_window", 16'((n >= 5005) && (n <= 5020)), 16'd1);
        repeat (20) @(posedge clock);
        check("t4_err", 16'(err_pulses), 16'd2);
        push(8'h29, 1'b0, 1'b1, 1'b1);
        send_byte(8'h29, 1'b0, HALF_FAST);
        check("t4_scan_code", 16'(scan_code), 16'h0029);
        push(8'hF0, 1'b0, 1'b1, 1'b1);
        send_byte(8'hF0, 1'b0, HALF_FAST);
        push(8'h29, 1'b0, 1'b1, 1'b0);
        send_byte(8'h29, 1'b0, HALF_FAST);
        check("t4_start_break", 16'(key_start), 16'd0);

        // 3-cycle low glitches on ps2_clk while idle
        saved_code = scan_code;
        saved_cv   = cv_count;
        saved_err  = err_pulses;
        for (int g = 0; g < 4; g++) begin
            @(posedge clock);
            ps2_clk = 1'b0;
            repeat (3) @(posedge clock);
            ps2_clk = 1'b1;
            repeat (20) @(posedge clock);
        end
        repeat (30) @(posedge clock);
        check("t5_glitch_cv",   16'(cv_count),   16'(saved_cv));
        check("t5_glitch_err",  16'(err_pulses), 16'(saved_err));
        check("t5_glitch_code", 16'(scan_code),  16'(saved_code));

        // Start bit of 1 in idle is an error
        send_bits(11'h7FF, 1, HALF_FAST);
        repeat (HALF_FAST) @(posedge clock);
        check("t6_bad_start", 16'(err_pulses), 16'd3);

        // Reset mid-frame with key_left held
        push(8'hE0, 1'b0, 1'b1, 1'b0);
        send_byte(8'hE0, 1'b0, HALF_FAST);
        push(8'h6B, 1'b1, 1'b1, 1'b0);
        send_byte(8'h6B, 1'b0, HALF_FAST);
        check("t7_left_held", 16'(key_left), 16'd1);
        send_bits(mkframe(8'h29, 1'b0), 3, HALF_FAST);
        @(posedge clock);
        #5 reset = 1'b1;
        #1;
        check("t7_async_rst", 16'({scan_code, code_valid, frame_error,
                                   key_left, key_right, key_start}), 16'h0000);
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        push(8'h29, 1'b0, 1'b0, 1'b1);
        send_byte(8'h29, 1'b0, HALF_FAST);
        check("t7_after_rst_start", 16'(key_start), 16'd1);
        check("t7_after_rst_code",  16'(scan_code), 16'h0029);

        // Totals
        check("sb_drained",      16'(exp_q.size()), 16'd0);
        check("total_cv",        16'(cv_count),     16'd14);
        check("total_err",       16'(err_pulses),   16'd3);
        check("err_one_cycle",   16'(err_cycles),   16'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
